multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_output_decode.sv | 76 +++++++
 rtl/multicycle_control.sv | 101 ++++++++++
 tb/tb_multicycle_control.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path and its datapath.
// Build option: MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB states and makes opcode 001000 legal.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_REXEC  = 4'd6,
        ST_RWB    = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
`ifdef MULTICYCLE_ADDI_EN
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
`endif
        ST_ERROR  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] SRCB_REG      = 3'b000;
    localparam logic [2:0] SRCB_FOUR     = 3'b001;
    localparam logic [2:0] SRCB_SEXT     = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SH2 = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [2:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // True for every opcode the decoder dispatches to a real instruction sequence.
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                (op == OP_BEQ) || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
        legal = legal || (op == OP_ADDI);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational Moore decode: control word as a pure function of the current state.
// Build option: MULTICYCLE_ADDI_EN enables decode of the ADDIEX/ADDIWB states.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            ST_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MULTICYCLE_ADDI_EN
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;  // ERROR and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register, opcode latch, sticky illegal flag.
// Build option: MULTICYCLE_ADDI_EN adds ADDI support (opcode 001000); otherwise it is illegal.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opCode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [2:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal
);

    state_t     state_q;
    logic [5:0] opcode_q;
    logic       illegal_q;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            opcode_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    // The live opcode is only trusted here; later states use opcode_q.
                    opcode_q <= opCode;
                    case (opCode)
                        OP_RTYPE:     state_q <= ST_REXEC;
                        OP_LW, OP_SW: state_q <= ST_MEMADR;
                        OP_BEQ:       state_q <= ST_BRANCH;
                        OP_J:         state_q <= ST_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      state_q <= ST_ADDIEX;
`endif
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= (ILLEGAL_HALT != 0) ? ST_ERROR : ST_FETCH;
                        end
                    endcase
                end
                ST_MEMADR: state_q <= (opcode_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
                ST_MEMRD:  state_q <= ST_MEMWB;
                ST_MEMWB:  state_q <= ST_FETCH;
                ST_MEMWR:  state_q <= ST_FETCH;
                ST_REXEC:  state_q <= ST_RWB;
                ST_RWB:    state_q <= ST_FETCH;
                ST_BRANCH: state_q <= ST_FETCH;
                ST_JUMP:   state_q <= ST_FETCH;
`ifdef MULTICYCLE_ADDI_EN
                ST_ADDIEX: state_q <= ST_ADDIWB;
                ST_ADDIWB: state_q <= ST_FETCH;
`endif
                ST_ERROR:  state_q <= ST_ERROR;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    mc_output_decode u_decode (
        .state (state_q),
        .ctrl  (dec_ctrl)
    );

    // Reset must suppress the FETCH decode so nothing is written while it is held.
    assign ctrl = reset ? '0 : dec_ctrl;

    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.ior_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign state       = state_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expectations queued by stimulus, checked by a monitor.
// Honours MULTICYCLE_ADDI_EN when deciding whether opcode 001000 is legal.
module tb_multicycle_control;

    localparam int HALT = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [3:0] state;
    logic       illegal;

    multicycle_control #(.ILLEGAL_HALT(HALT)) dut (
        .clk(clk), .reset(reset), .opCode(opCode),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        logic [3:0] st;
        logic [16:0] ctl;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   trace[$];
    int   total = 0;
    int   bad = 0;
    bit   draining = 0;
    int   drain_cnt = 0;
    bit   ill_model = 0;

    // Expected control word per state, in the port order of the monitor's packing.
    function automatic logic [16:0] spec_ctrl(input int s);
        logic pcwc = 0, pcw = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        logic irw = 0, srca = 0, rw = 0, rdst = 0;
        logic [1:0] pcs = 0;
        logic [2:0] srcb = 0;
        logic [1:0] aop = 0;
        case (s)
            0:  begin mrd = 1; irw = 1; pcw = 1; srcb = 3'b001; end
            1:  begin srcb = 3'b011; aop = 2'b00; end
            2:  begin srca = 1; srcb = 3'b010; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin srca = 1; srcb = 3'b010; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, srcb, aop};
    endfunction

    function automatic bit spec_legal(input logic [5:0] op);
        bit ok;
        ok = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
`ifdef MULTICYCLE_ADDI_EN
        ok = ok || (op == 6'd8);
`endif
        return ok;
    endfunction

    // Sequence of states visited from FETCH until the next FETCH (or ten cycles of ERROR).
    task automatic build_trace(input logic [5:0] op);
        trace = {0, 1};
        if (!spec_legal(op)) begin
            if (HALT != 0) for (int i = 0; i < 10; i++) trace.push_back(15);
        end else begin
            case (op)
                6'd0:  begin trace.push_back(6); trace.push_back(7); end
                6'd35: begin trace.push_back(2); trace.push_back(3); trace.push_back(4); end
                6'd43: begin trace.push_back(2); trace.push_back(5); end
                6'd4:  trace.push_back(8);
                6'd2:  trace.push_back(9);
                default: begin trace.push_back(10); trace.push_back(11); end
            endcase
        end
    endtask

    task automatic do_reset(input int ncyc);
        exp_t e;
        for (int i = 0; i < ncyc; i++) begin
            reset = 1'b1;
            opCode = 6'($urandom_range(0, 63));
            e.chk = (i > 0); e.st = 4'd0; e.ctl = '0; e.ill = 1'b0;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        ill_model = 0;
    endtask

    // keep: 0 runs the whole sequence, -1 cuts it at a random point, >0 cuts after that many cycles.
    // after: value held on opCode after DECODE, or -1 for random noise.
    task automatic run_instr(input logic [5:0] op, input int keep, input int after);
        exp_t e;
        int   n;
        bit   ill_after;
        build_trace(op);
        n = trace.size();
        if (keep == -1) n = $urandom_range(1, trace.size() - 1);
        else if (keep > 0 && keep < trace.size()) n = keep;
        ill_after = ill_model || !spec_legal(op);
        for (int i = 0; i < n; i++) begin
            e.chk = 1; e.st = 4'(trace[i]); e.ctl = spec_ctrl(trace[i]);
            e.ill = (i >= 2) ? ill_after : ill_model;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (i == 1) opCode = op;
            else if (i >= 2 && after >= 0) opCode = after[5:0];
            else opCode = 6'($urandom_range(0, 63));
            @(posedge clk); #1;
        end
        if (n >= 2) ill_model = ill_after;
        if (n < trace.size() || (!spec_legal(op) && HALT != 0))
            do_reset($urandom_range(1, 2));
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [16:0] got;
        got = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};
        total++;
        if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
            bad++;
            $display("FAIL excl t=%0t: got rd=%b wr=%b rw=%b, required no overlap", $time,
                     MemRead, MemWrite, RegWrite);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (got !== e.ctl) begin
                bad++;
                $display("FAIL ctrl t=%0t state=%0d: got %b required %b", $time, state, got, e.ctl);
            end
            if (e.chk) begin
                total++;
                if (state !== e.st) begin
                    bad++;
                    $display("FAIL state t=%0t: got %0d required %0d", $time, state, e.st);
                end
                total++;
                if (illegal !== e.ill) begin
                    bad++;
                    $display("FAIL illegal t=%0t: got %b required %b", $time, illegal, e.ill);
                end
            end
        end
        if (draining) begin
            drain_cnt++;
            if (drain_cnt == 2) begin
                total++;
                if (sb.size() != 0) begin
                    bad++;
                    $display("FAIL drain: got %0d pending entries required 0", sb.size());
                end
            end
        end
    end

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        int r;
        ops[0] = 6'd0; ops[1] = 6'd35; ops[2] = 6'd43;
        ops[3] = 6'd4; ops[4] = 6'd2;  ops[5] = 6'd8;
        reset = 1'b1;
        opCode = 6'd0;
        @(posedge clk); #1;
        do_reset(2);
        run_instr(6'b100011, 0, -1);
        run_instr(6'b101011, 0, 0);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b000010, 0, -1);
        run_instr(6'b001000, 0, -1);
        run_instr(6'b111111, 0, -1);
        run_instr(6'b100011, 3, -1);
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 7);
            if (r < 6) op = ops[r];
            else op = 6'($urandom_range(0, 63));
            run_instr(op, ($urandom_range(0, 5) == 0) ? -1 : 0, -1);
        end
        draining = 1;
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
